// File: rtl/alu_operand_fetch.sv
// Operand fetch stage: captures a PHV and VLIW sub-action, selects ALU operands, and issues to the ALU.
// Optional per-tenant page table is enabled with `define PAGE_TBL_EN; otherwise a fixed entry is reported.
module alu_operand_fetch #(
    parameter int ACTION_LEN     = 25,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CONTAINERS = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CONTAINERS*DATA_WIDTH-1:0] phv_in,
    input  logic [ACTION_LEN-1:0]              action_in,
    input  logic [3:0]                         tenant_id_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               cfg_wr_en,
    input  logic [3:0]                         cfg_wr_addr,
    input  logic [15:0]                        cfg_wr_data,
    output logic [ACTION_LEN-1:0]              action_out,
    output logic                               action_valid,
    output logic [DATA_WIDTH-1:0]              operand_1_out,
    output logic [DATA_WIDTH-1:0]              operand_2_out,
    output logic [DATA_WIDTH-1:0]              operand_3_out,
    output logic [15:0]                        page_tbl_out,
    output logic                               page_tbl_out_valid,
    input  logic                               alu_ready
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WAIT_ALU,
        ISSUE,
        GUARD
    } state_t;

    state_t state_reg, state_next;

    logic [NUM_CONTAINERS*DATA_WIDTH-1:0] phv_reg;
    logic [ACTION_LEN-1:0]                action_reg;
    logic                                 capture;

    logic [ACTION_LEN-1:0] action_out_reg;
    logic [DATA_WIDTH-1:0] operand_1_reg;
    logic [DATA_WIDTH-1:0] operand_2_reg;
    logic [DATA_WIDTH-1:0] operand_3_reg;
    logic [15:0]           page_tbl_out_reg;

    logic [3:0]            opcode;
    logic [2:0]            op1_idx;
    logic [2:0]            dest_idx;
    logic [2:0]            op2_idx;
    logic [14:0]           imm;
    logic [DATA_WIDTH-1:0] container [8];
    logic [DATA_WIDTH-1:0] operand_2_next;
    logic [15:0]           page_tbl_entry;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (in_valid) state_next = LOOKUP;
            LOOKUP:   state_next = WAIT_ALU;
            WAIT_ALU: if (alu_ready) state_next = ISSUE;
            ISSUE:    state_next = GUARD;
            GUARD:    state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign in_ready           = (state_reg == IDLE);
    assign action_valid       = (state_reg == ISSUE);
    assign page_tbl_out_valid = (state_reg == ISSUE);
    assign capture            = (state_reg == IDLE) && in_valid;

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_reg    <= '0;
            action_reg <= '0;
        end else if (capture) begin
            phv_reg    <= phv_in;
            action_reg <= action_in;
        end
    end

    // ------------------------------------------------------------------
    // Action decode and operand selection
    // ------------------------------------------------------------------
    assign opcode   = action_reg[24:21];
    assign op1_idx  = action_reg[20:18];
    assign dest_idx = action_reg[17:15];
    assign op2_idx  = action_reg[14:12];
    assign imm      = action_reg[14:0];

    // Indices are 3 bits wide; slots beyond NUM_CONTAINERS read as zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_container
            if (gi < NUM_CONTAINERS) begin : g_present
                assign container[gi] = phv_reg[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_absent
                assign container[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        operand_2_next = container[op2_idx];
        case (opcode)
            4'b0001, 4'b0010: operand_2_next = container[op2_idx];
            4'b1001, 4'b1010, 4'b1000, 4'b1011, 4'b0111, 4'b1110:
                operand_2_next = DATA_WIDTH'(imm);
            default:          operand_2_next = container[op2_idx];
        endcase
    end

    // ------------------------------------------------------------------
    // Tenant page table
    // ------------------------------------------------------------------
`ifdef PAGE_TBL_EN
    logic [3:0]  tenant_reg;
    logic [15:0] page_tbl [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tenant_reg <= '0;
        end else if (capture) begin
            tenant_reg <= tenant_id_in;
        end
    end

    // Writes land at the edge, so a same-cycle LOOKUP sees the previous entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                page_tbl[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            page_tbl[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    assign page_tbl_entry = page_tbl[tenant_reg];
`else
    logic cfg_unused;

    assign cfg_unused     = ^{cfg_wr_en, cfg_wr_addr, cfg_wr_data, tenant_id_in};
    assign page_tbl_entry = 16'h1F00;
`endif

    // ------------------------------------------------------------------
    // Output registers: loaded on LOOKUP exit, held until the next lookup
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            action_out_reg   <= '0;
            operand_1_reg    <= '0;
            operand_2_reg    <= '0;
            operand_3_reg    <= '0;
            page_tbl_out_reg <= '0;
        end else if (state_reg == LOOKUP) begin
            action_out_reg   <= action_reg;
            operand_1_reg    <= container[op1_idx];
            operand_2_reg    <= operand_2_next;
            operand_3_reg    <= container[dest_idx];
            page_tbl_out_reg <= page_tbl_entry;
        end
    end

    assign action_out    = action_out_reg;
    assign operand_1_out = operand_1_reg;
    assign operand_2_out = operand_2_reg;
    assign operand_3_out = operand_3_reg;
    assign page_tbl_out  = page_tbl_out_reg;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed self-checking bench for alu_operand_fetch; expectations follow the PAGE_TBL_EN build setting.
module tb_alu_operand_fetch;

    logic         clk;
    logic         rst_n;
    logic [255:0] phv_in;
    logic [24:0]  action_in;
    logic [3:0]   tenant_id_in;
    logic         in_valid;
    logic         in_ready;
    logic         cfg_wr_en;
    logic [3:0]   cfg_wr_addr;
    logic [15:0]  cfg_wr_data;
    logic [24:0]  action_out;
    logic         action_valid;
    logic [31:0]  operand_1_out;
    logic [31:0]  operand_2_out;
    logic [31:0]  operand_3_out;
    logic [15:0]  page_tbl_out;
    logic         page_tbl_out_valid;
    logic         alu_ready;

    int errors = 0;
    int checks = 0;

`ifdef PAGE_TBL_EN
    localparam logic [15:0] EXP_T3     = 16'h0A10;
    localparam logic [15:0] EXP_OLD7   = 16'h0000;
    localparam logic [15:0] EXP_NEW7   = 16'h0505;
    localparam logic [15:0] EXP_T3_RST = 16'h0000;
`else
    localparam logic [15:0] EXP_T3     = 16'h1F00;
    localparam logic [15:0] EXP_OLD7   = 16'h1F00;
    localparam logic [15:0] EXP_NEW7   = 16'h1F00;
    localparam logic [15:0] EXP_T3_RST = 16'h1F00;
`endif

    // containers 0..7 = 42, 11, 100, 33, 9, 55, 7, 77
    localparam logic [255:0] PHV = {32'd77, 32'd7, 32'd55, 32'd9, 32'd33, 32'd100, 32'd11, 32'd42};

    alu_operand_fetch dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .phv_in             (phv_in),
        .action_in          (action_in),
        .tenant_id_in       (tenant_id_in),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_wr_addr        (cfg_wr_addr),
        .cfg_wr_data        (cfg_wr_data),
        .action_out         (action_out),
        .action_valid       (action_valid),
        .operand_1_out      (operand_1_out),
        .operand_2_out      (operand_2_out),
        .operand_3_out      (operand_3_out),
        .page_tbl_out       (page_tbl_out),
        .page_tbl_out_valid (page_tbl_out_valid),
        .alu_ready          (alu_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after capture.
    task automatic send(input logic [24:0] a, input logic [3:0] t);
        action_in    = a;
        tenant_id_in = t;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid     = 1'b0;
    endtask

    // Send a request and wait (bounded) for the issue pulse; checks 3-cycle latency.
    task automatic req(input string tag, input logic [24:0] a, input logic [3:0] t);
        int n;
        send(a, t);
        n = 1;
        while (!action_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd3);
        chk({tag, "_action_out"}, 64'(action_out), 64'(a));
        chk({tag, "_pt_valid"}, 64'(page_tbl_out_valid), 64'd1);
        $display("req %s action=%h tenant=%0d op1=%0h op2=%0h op3=%0h pt=%h", tag, a, t,
                 operand_1_out, operand_2_out, operand_3_out, page_tbl_out);
    endtask

    task automatic back_to_idle(input string tag);
        @(negedge clk);
        chk({tag, "_guard_no_issue"}, 64'(action_valid), 64'd0);
        chk({tag, "_guard_not_ready"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [24:0] act;
        int          seen;
        int          caps;
        int          pulses;

        rst_n        = 1'b0;
        phv_in       = PHV;
        action_in    = '0;
        tenant_id_in = '0;
        in_valid     = 1'b0;
        cfg_wr_en    = 1'b0;
        cfg_wr_addr  = '0;
        cfg_wr_data  = '0;
        alu_ready    = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_action_valid", 64'(action_valid), 64'd0);
        chk("rst_pt_valid", 64'(page_tbl_out_valid), 64'd0);
        chk("rst_action_out", 64'(action_out), 64'd0);
        chk("rst_op1", 64'(operand_1_out), 64'd0);
        chk("rst_op2", 64'(operand_2_out), 64'd0);
        chk("rst_op3", 64'(operand_3_out), 64'd0);
        chk("rst_pt_out", 64'(page_tbl_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Program tenant 3, then immediate-opcode request with cycle-by-cycle checks
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 4'd3;
        cfg_wr_data = 16'h0A10;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
        act = {4'b1011, 3'd0, 3'd0, 15'd5};
        send(act, 4'd3);
        chk("t1_c1_not_ready", 64'(in_ready), 64'd0);
        chk("t1_c1_no_issue", 64'(action_valid), 64'd0);
        @(negedge clk);
        chk("t1_c2_no_issue", 64'(action_valid), 64'd0);
        chk("t1_c2_action_out", 64'(action_out), 64'(act));
        @(negedge clk);
        chk("t1_c3_issue", 64'(action_valid), 64'd1);
        chk("t1_c3_pt_valid", 64'(page_tbl_out_valid), 64'd1);
        chk("t1_op1", 64'(operand_1_out), 64'd42);
        chk("t1_op2_imm", 64'(operand_2_out), 64'd5);
        chk("t1_op3", 64'(operand_3_out), 64'd42);
        chk("t1_pt_out", 64'(page_tbl_out), 64'(EXP_T3));
        $display("req t1 action=%h tenant=3 op2=%0h pt=%h", act, operand_2_out, page_tbl_out);
        back_to_idle("t1");

        // Register operands, opcode 0001
        req("t2a", {4'b0001, 3'd2, 3'd4, 3'd6, 12'h000}, 4'd0);
        chk("t2a_op1", 64'(operand_1_out), 64'd100);
        chk("t2a_op2", 64'(operand_2_out), 64'd7);
        chk("t2a_op3", 64'(operand_3_out), 64'd9);
        back_to_idle("t2a");

        // Unlisted opcode takes register operand even with nonzero low bits
        req("t2b", {4'b0011, 3'd1, 3'd7, 3'd6, 12'hABC}, 4'd0);
        chk("t2b_op1", 64'(operand_1_out), 64'd11);
        chk("t2b_op2", 64'(operand_2_out), 64'd7);
        chk("t2b_op3", 64'(operand_3_out), 64'd77);
        back_to_idle("t2b");

        // Maximum immediate, zero-extended
        req("t2c", {4'b0111, 3'd5, 3'd3, 15'h7FFF}, 4'd0);
        chk("t2c_op1", 64'(operand_1_out), 64'd55);
        chk("t2c_op2", 64'(operand_2_out), 64'h7FFF);
        chk("t2c_op3", 64'(operand_3_out), 64'd33);
        back_to_idle("t2c");

        req("t2d", {4'b0010, 3'd0, 3'd0, 3'd5, 12'h123}, 4'd0);
        chk("t2d_op2", 64'(operand_2_out), 64'd55);
        back_to_idle("t2d");

        req("t2e", {4'b1001, 3'd0, 3'd0, 15'h1234}, 4'd0);
        chk("t2e_op2", 64'(operand_2_out), 64'h1234);
        back_to_idle("t2e");

        // ALU stall for 10 cycles
        alu_ready = 1'b0;
        act = {4'b0001, 3'd7, 3'd1, 3'd2, 12'h000};
        send(act, 4'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (action_valid) seen++;
        end
        chk("t3_no_issue_while_stalled", 64'(seen), 64'd0);
        chk("t3_held_action", 64'(action_out), 64'(act));
        chk("t3_held_op1", 64'(operand_1_out), 64'd77);
        chk("t3_held_op2", 64'(operand_2_out), 64'd100);
        chk("t3_held_op3", 64'(operand_3_out), 64'd11);
        alu_ready = 1'b1;
        @(negedge clk);
        chk("t3_issue_after_ready", 64'(action_valid), 64'd1);
        $display("req t3 action=%h issued after stall", act);
        back_to_idle("t3");

        // in_valid held high: capture every 5 cycles, mid-request inputs ignored
        caps = 0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            action_in = {4'b0011, 21'(k)};
            in_valid  = 1'b1;
            if (in_ready) caps++;
            if (action_valid) begin
                pulses++;
                chk("t4_pulse_slot", 64'(k % 5), 64'd3);
                chk("t4_action_captured", 64'(action_out), 64'({4'b0011, 21'(k - 3)}));
                $display("req t4 cycle=%0d action=%h", k, action_out);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t4_captures", 64'(caps), 64'd4);
        chk("t4_pulses", 64'(pulses), 64'd4);

        // Config write colliding with LOOKUP of the same entry
        act = {4'b0001, 3'd0, 3'd0, 3'd0, 12'h000};
        send(act, 4'd7);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 4'd7;
        cfg_wr_data = 16'h0505;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
        @(negedge clk);
        chk("t5_issue", 64'(action_valid), 64'd1);
        chk("t5_pt_old", 64'(page_tbl_out), 64'(EXP_OLD7));
        $display("req t5 tenant=7 pt=%h", page_tbl_out);
        back_to_idle("t5");
        req("t5b", act, 4'd7);
        chk("t5b_pt_new", 64'(page_tbl_out), 64'(EXP_NEW7));
        back_to_idle("t5b");

        // Reset during WAIT_ALU aborts the request
        alu_ready = 1'b0;
        send({4'b1011, 3'd0, 3'd0, 15'd9}, 4'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_ready", 64'(in_ready), 64'd1);
        chk("t6_async_no_issue", 64'(action_valid), 64'd0);
        chk("t6_async_action_out", 64'(action_out), 64'd0);
        chk("t6_async_op2", 64'(operand_2_out), 64'd0);
        chk("t6_async_pt_out", 64'(page_tbl_out), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        alu_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (action_valid) seen++;
        end
        chk("t6_no_issue_after_reset", 64'(seen), 64'd0);
        chk("t6_ready_after_reset", 64'(in_ready), 64'd1);
        req("t6b", {4'b1011, 3'd0, 3'd0, 15'd1}, 4'd3);
        chk("t6b_pt_after_reset", 64'(page_tbl_out), 64'(EXP_T3_RST));
        back_to_idle("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
